multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MEM_WAIT, default 0, range 0..15: extra wait cycles per memory access state (FETCH, MEMREAD, MEMWRITE).
REQ-002 clk  input  1  rising-edge clock, the only clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 op, funct3, funct7_5, Zero  input  7/3/1/1  instruction opcode, funct3, funct7 bit 5, ALU zero flag.
REQ-005 PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  output  1 each  PC enable, address mux select (0=PC, 1=Result), data store strobe, IR enable, register file write.
REQ-006 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  output  2 each  Result mux, ALU A/B mux, immediate format selects.
REQ-007 ALUControl  output  3  ALU operation; state  output  4  current FSM state, for observation.
REQ-008 illegal_op  output  1  one-cycle pulse in DECODE when op is unsupported.

Function
REQ-009 The block SHALL be a Moore FSM: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, JAL=10; codes 11..15 SHALL go to FETCH on the next clock.
REQ-010 Transitions SHALL be FETCH->DECODE; DECODE->MEMADR (op 0000011 or 0100011), EXECUTER (0110011), EXECUTEI (0010011), BRANCH (1100011), JAL (1101111), otherwise FETCH with illegal_op=1; MEMADR->MEMREAD (op[5]=0) or MEMWRITE (op[5]=1); MEMREAD->MEMWB; EXECUTER/EXECUTEI/JAL->ALUWB; MEMWB, MEMWRITE, ALUWB, BRANCH->FETCH.
REQ-011 A 4-bit wait counter SHALL clear on entry to every state; FETCH, MEMREAD and MEMWRITE SHALL hold until counter==MEM_WAIT, so each lasts MEM_WAIT+1 cycles; all other states last exactly 1 cycle.
REQ-012 Fetch strobes IRWrite=1 and PCWrite=1 SHALL assert only on the final FETCH cycle; MemWrite=1 only on the final MEMWRITE cycle.
REQ-013 Output values per state (A, B, ResultSrc, AdrSrc, ALUOp): FETCH 00,10,10,0,00; DECODE 01,01,--,0,00; MEMADR 10,01,--,0,00; MEMREAD --,--,00,1,--; MEMWB --,--,01,0,-- with RegWrite=1; MEMWRITE --,--,00,1,--; EXECUTER 10,00,--,0,10; EXECUTEI 10,01,--,0,10; ALUWB --,--,00,0,-- with RegWrite=1; BRANCH 10,00,00,0,01; JAL 01,10,00,0,00 with PCWrite=1. Every "--" SHALL drive 0.
REQ-014 ALUOp is internal; ALUControl SHALL be 000 (add) for ALUOp 00 and 001 (sub) for ALUOp 01; for ALUOp 10 funct3 000 SHALL give 001 when op[5]&funct7_5, else 000; funct3 010 gives 101, 110 gives 011, 111 gives 010, any other funct3 gives 000.
REQ-015 ImmSrc SHALL be combinational on op in every state: 0010011/0000011 -> 00, 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, else 00.
REQ-016 In BRANCH, PCWrite SHALL equal branch_taken (REQ-021/022) in the same cycle.
REQ-017 RegWrite, MemWrite, PCWrite and IRWrite SHALL never assert in DECODE or in unused state codes.

Reset
REQ-018 reset=1 SHALL force state=FETCH and counter=0 immediately, without waiting for clk.
REQ-019 While reset=1 every strobe (PCWrite, IRWrite, MemWrite, RegWrite, illegal_op) SHALL be 0; mux selects SHALL take the FETCH values.
REQ-020 Reset asserted mid-instruction, including mid-wait, SHALL abort it with no further strobes; the first FETCH after release SHALL last MEM_WAIT+1 cycles.

Configuration
REQ-021 With BRANCH_EXT_EN defined, branch_taken SHALL be Zero for funct3 000 (beq), ~Zero for 001 (bne), and 0 for any other funct3.
REQ-022 Without BRANCH_EXT_EN, branch_taken SHALL be Zero regardless of funct3.

Verification
REQ-023 MEM_WAIT=0, op=0000011 -> states 0,1,2,3,4,0; RegWrite=1 only in state 4, ResultSrc=01; 5 cycles total.
REQ-024 MEM_WAIT=2, op=0100011 -> FETCH 3 cycles with IRWrite on the 3rd only; MEMWRITE 3 cycles with MemWrite on the 3rd only.
REQ-025 op=0110011, funct3=000, funct7_5=1 -> EXECUTER with ALUControl=001; ALUWB with RegWrite=1, ResultSrc=00.
REQ-026 op=1100011, funct3=001, Zero=0 -> PCWrite=1 in BRANCH with BRANCH_EXT_EN defined, 0 without it; Zero=1 inverts both results.
REQ-027 op=1111111 -> illegal_op=1 for one cycle in DECODE, then FETCH; no RegWrite or MemWrite.
REQ-028 reset pulsed during MEMREAD wait with MEM_WAIT=3 -> state=0 asynchronously, all strobes 0, next FETCH 4 cycles.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM with wait states on memory-access states.
// Define BRANCH_EXT_EN to make BRANCH honour funct3 (beq/bne) instead of taking on Zero alone.
module multicycle_control #(
    parameter int MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] state,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    state_t     state_q, state_d;
    logic [3:0] wait_cnt;
    logic [1:0] alu_op;
    logic       wait_done;
    logic       branch_taken;

    function automatic logic [2:0] alu_decode(input logic [1:0] aop, input logic [2:0] f3,
                                              input logic sub_sel);
        logic [2:0] ctl;
        ctl = 3'b000;
        case (aop)
            2'b01: ctl = 3'b001;
            2'b10: begin
                case (f3)
                    3'b000:  ctl = sub_sel ? 3'b001 : 3'b000;
                    3'b010:  ctl = 3'b101;
                    3'b110:  ctl = 3'b011;
                    3'b111:  ctl = 3'b010;
                    default: ctl = 3'b000;
                endcase
            end
            default: ctl = 3'b000;
        endcase
        return ctl;
    endfunction

`ifdef BRANCH_EXT_EN
    assign branch_taken = (funct3 == 3'b000) ? Zero :
                          (funct3 == 3'b001) ? ~Zero : 1'b0;
`else
    assign branch_taken = Zero;
`endif

    assign wait_done  = (wait_cnt == WAIT_LAST);
    assign state      = state_q;
    assign ALUControl = alu_decode(alu_op, funct3, op[5] & funct7_5);

    // The wait counter restarts whenever the state changes, so only held states accumulate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_FETCH;
            wait_cnt <= 4'd0;
        end else begin
            state_q  <= state_d;
            wait_cnt <= (state_d != state_q) ? 4'd0 : wait_cnt + 4'd1;
        end
    end

    always_comb begin
        case (op)
            OP_ITYPE, OP_LOAD: ImmSrc = 2'b00;
            OP_STORE:          ImmSrc = 2'b01;
            OP_BRANCH:         ImmSrc = 2'b10;
            OP_JAL:            ImmSrc = 2'b11;
            default:           ImmSrc = 2'b00;
        endcase
    end

    always_comb begin
        state_d    = S_FETCH;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        alu_op     = 2'b00;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (wait_done) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTER;
                    OP_ITYPE:          state_d = S_EXECUTEI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = wait_done ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                if (wait_done) begin
                    MemWrite = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_MEMWRITE;
                end
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                PCWrite = branch_taken;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
                state_d = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
        // Reset already parks the state in FETCH; only the strobes need masking.
        if (reset) begin
            PCWrite    = 1'b0;
            IRWrite    = 1'b0;
            MemWrite   = 1'b0;
            RegWrite   = 1'b0;
            illegal_op = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: two instances (MEM_WAIT 0 and 3) checked cycle by cycle
// against a state-path/output-table reference model.
module tb_multicycle_control;

    localparam int W0 = 0;
    localparam int W1 = 3;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic       rw;
        logic [1:0] rs;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] imm;
        logic [2:0] alu;
        logic [3:0] st;
        logic       ill;
    } obs_t;

    logic       clk;
    logic       rst_v [2];
    logic [6:0] op_v  [2];
    logic [2:0] f3_v  [2];
    logic       f7_v  [2];
    logic       z_v   [2];
    obs_t       obs   [2];

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic       pcw, adr, mw, irw, rw, ill;
        logic [1:0] rs, a, b, imm;
        logic [2:0] alu;
        logic [3:0] st;
        multicycle_control #(.MEM_WAIT(g == 0 ? W0 : W1)) dut (
            .clk        (clk),
            .reset      (rst_v[g]),
            .op         (op_v[g]),
            .funct3     (f3_v[g]),
            .funct7_5   (f7_v[g]),
            .Zero       (z_v[g]),
            .PCWrite    (pcw),
            .AdrSrc     (adr),
            .MemWrite   (mw),
            .IRWrite    (irw),
            .RegWrite   (rw),
            .ResultSrc  (rs),
            .ALUSrcA    (a),
            .ALUSrcB    (b),
            .ImmSrc     (imm),
            .ALUControl (alu),
            .state      (st),
            .illegal_op (ill)
        );
        assign obs[g] = {pcw, adr, mw, irw, rw, rs, a, b, imm, alu, st, ill};
    end

    function automatic bit is_legal(input logic [6:0] op);
        return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
    endfunction

    function automatic logic [1:0] imm_ref(input logic [6:0] op);
        if (op == 7'b0100011) return 2'b01;
        if (op == 7'b1100011) return 2'b10;
        if (op == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [2:0] arith_ref(input logic [2:0] f3, input logic sub);
        if (f3 == 3'b000) return sub ? 3'b001 : 3'b000;
        if (f3 == 3'b010) return 3'b101;
        if (f3 == 3'b110) return 3'b011;
        if (f3 == 3'b111) return 3'b010;
        return 3'b000;
    endfunction

    function automatic logic taken_ref(input logic [2:0] f3, input logic z);
`ifdef BRANCH_EXT_EN
        if (f3 == 3'b000) return z;
        if (f3 == 3'b001) return !z;
        return 1'b0;
`else
        return z;
`endif
    endfunction

    // Expected outputs for state s; 'last' marks the final cycle of a held state.
    function automatic obs_t exp_obs(input int s, input bit last, input logic [6:0] op,
                                     input logic [2:0] f3, input logic f7, input logic z);
        obs_t e;
        e     = '0;
        e.imm = imm_ref(op);
        e.st  = 4'(s);
        case (s)
            0: begin e.a = 0; e.b = 2; e.rs = 2; e.irw = last; e.pcw = last; end
            1: begin e.a = 1; e.b = 1; e.ill = !is_legal(op); end
            2: begin e.a = 2; e.b = 1; end
            3: begin e.rs = 0; e.adr = 1; end
            4: begin e.rs = 1; e.rw = 1; end
            5: begin e.adr = 1; e.mw = last; end
            6: begin e.a = 2; e.b = 0; e.alu = arith_ref(f3, op[5] & f7); end
            7: begin e.a = 2; e.b = 1; e.alu = arith_ref(f3, op[5] & f7); end
            8: begin e.rw = 1; end
            9: begin e.a = 2; e.b = 0; e.alu = 3'b001; e.pcw = taken_ref(f3, z); end
            10: begin e.a = 1; e.b = 2; e.pcw = 1; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic check(input string tag, input obs_t got, input obs_t exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h (state %0d) expected=%h (state %0d)",
                   tag, got, got.st, exp, exp.st);
        end
    endtask

    // Runs one instruction from its first FETCH cycle; stops early after stop_after cycles if >= 0.
    task automatic run_instr(input int d, input int w, input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic z, input string tag, input int stop_after);
        int path[$];
        int n;
        op_v[d] = op; f3_v[d] = f3; f7_v[d] = f7; z_v[d] = z;
        path = {0, 1};
        case (op)
            7'b0000011: path = {path, 2, 3, 4};
            7'b0100011: path = {path, 2, 5};
            7'b0110011: path = {path, 6, 8};
            7'b0010011: path = {path, 7, 8};
            7'b1100011: path = {path, 9};
            7'b1101111: path = {path, 10, 8};
            default: ;
        endcase
        #1;
        n = 0;
        foreach (path[i]) begin
            int len;
            len = (path[i] == 0 || path[i] == 3 || path[i] == 5) ? w + 1 : 1;
            for (int k = 0; k < len; k++) begin
                if (stop_after >= 0 && n == stop_after) return;
                check($sformatf("%s_s%0d_c%0d", tag, path[i], k), obs[d],
                      exp_obs(path[i], k == len - 1, op, f3, f7, z));
                @(posedge clk);
                #2;
                n++;
            end
        end
    endtask

    function automatic obs_t reset_obs(input logic [6:0] op);
        return exp_obs(0, 1'b0, op, 3'b000, 1'b0, 1'b0);
    endfunction

    task automatic run_random(input int d, input int w, input int count);
        logic [6:0] legal [6];
        logic [6:0] op;
        legal = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
        for (int i = 0; i < count; i++) begin
            int r;
            r  = $urandom_range(0, 7);
            op = (r < 6) ? legal[r] : 7'($urandom);
            run_instr(d, w, op, 3'($urandom), 1'($urandom), 1'($urandom),
                      $sformatf("rnd%0d_%0d", d, i), -1);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_v[i] = 1'b1; op_v[i] = 7'd0; f3_v[i] = 3'd0; f7_v[i] = 1'b0; z_v[i] = 1'b0;
        end
        #1;
        check("reset_async0", obs[0], reset_obs(7'd0));
        check("reset_async1", obs[1], reset_obs(7'd0));
        @(posedge clk); #2;
        check("reset_hold0", obs[0], reset_obs(7'd0));

        // MEM_WAIT=0 instance: directed instructions
        rst_v[0] = 1'b0;
        run_instr(0, W0, 7'b0000011, 3'b010, 1'b0, 1'b0, "load_w0", -1);
        run_instr(0, W0, 7'b0100011, 3'b010, 1'b0, 1'b0, "store_w0", -1);
        run_instr(0, W0, 7'b0110011, 3'b000, 1'b1, 1'b0, "sub_w0", -1);
        run_instr(0, W0, 7'b0110011, 3'b111, 1'b0, 1'b0, "and_w0", -1);
        run_instr(0, W0, 7'b0010011, 3'b000, 1'b1, 1'b0, "addi_w0", -1);
        run_instr(0, W0, 7'b0010011, 3'b110, 1'b0, 1'b0, "ori_w0", -1);
        run_instr(0, W0, 7'b1100011, 3'b001, 1'b0, 1'b0, "bne_z0", -1);
        run_instr(0, W0, 7'b1100011, 3'b001, 1'b0, 1'b1, "bne_z1", -1);
        run_instr(0, W0, 7'b1100011, 3'b000, 1'b0, 1'b1, "beq_z1", -1);
        run_instr(0, W0, 7'b1100011, 3'b100, 1'b0, 1'b1, "blt_z1", -1);
        run_instr(0, W0, 7'b1101111, 3'b000, 1'b0, 1'b0, "jal_w0", -1);
        run_instr(0, W0, 7'b1111111, 3'b000, 1'b0, 1'b0, "illegal_w0", -1);
        run_instr(0, W0, 7'b0010011, 3'b010, 1'b0, 1'b0, "slti_w0", -1);
        rst_v[0] = 1'b1;
        #1;
        check("reset_w0_idle", obs[0], reset_obs(7'b0010011));

        // MEM_WAIT=3 instance: stretched memory states and reset mid-wait
        @(posedge clk); #2;
        rst_v[1] = 1'b0;
        run_instr(1, W1, 7'b0100011, 3'b010, 1'b0, 1'b0, "store_w3", -1);
        run_instr(1, W1, 7'b0000011, 3'b010, 1'b0, 1'b0, "load_w3", -1);
        run_instr(1, W1, 7'b0000011, 3'b010, 1'b0, 1'b0, "load_abort", W1 + 1 + 1 + 1 + 2);
        rst_v[1] = 1'b1;
        #1;
        check("reset_midwait_async", obs[1], reset_obs(7'b0000011));
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #2;
            check($sformatf("reset_midwait_hold%0d", i), obs[1], reset_obs(7'b0000011));
        end
        rst_v[1] = 1'b0;
        run_instr(1, W1, 7'b0000011, 3'b010, 1'b0, 1'b0, "load_after_reset", -1);
        run_random(1, W1, 30);
        rst_v[1] = 1'b1;

        @(posedge clk); #2;
        rst_v[0] = 1'b0;
        run_random(0, W0, 30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
